// File: rtl/register_file_pkg.sv
// Shared register-file definitions: address width, XZR index and default
// data width. Kept beside the ALU opcode defines so control decode, ALU and
// register file agree on the same constants.
`ifndef REGISTER_FILE_PKG_DEFS
`define REGISTER_FILE_PKG_DEFS
`define REG_XZR 5'd31
`define REG_ADDR_W 5
`endif

package register_file_pkg;

   // Default width of every register and bus.
   localparam int REG_DATA_W = 64;

   // Architectural register count; the 5-bit address depends on it.
   localparam int REG_COUNT = 32;

endpackage

// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 register file with two combinational read ports and one
// synchronous write port. Entry 31 (XZR) reads as zero and ignores writes, so
// it has no storage. Optional same-cycle write-to-read forwarding is enabled
// by defining REGFILE_BYPASS_EN; the default build reads stored contents only.
module register_file
   import register_file_pkg::*;
#(
   parameter int n        = REG_DATA_W,
   parameter int NREG     = REG_COUNT,
   parameter int ZERO_REG = `REG_XZR
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [`REG_ADDR_W-1:0] RA,
   input  logic [`REG_ADDR_W-1:0] RB,
   input  logic [`REG_ADDR_W-1:0] RW,
   input  logic                   RegWr,
   input  logic [n-1:0]           BusW,
   output logic [n-1:0]           BusA,
   output logic [n-1:0]           BusB
);

   localparam logic [`REG_ADDR_W-1:0] XZR = `REG_ADDR_W'(ZERO_REG);

   // Storage only for entries 0..30; XZR (the last index) is never stored.
   logic [n-1:0] regs [0:NREG-2];

   // A write is real only when enabled and not aimed at XZR.
   logic wr_ok;
   assign wr_ok = RegWr && (RW != XZR);

   // Storage update: asynchronous clear, otherwise one write per rising edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NREG - 1; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[RW] <= BusW;
      end
   end

   // Read muxes: XZR forces zero; optional forwarding of the in-flight write.
   always_comb begin
      BusA = '0;
      BusB = '0;
      if (RA != XZR) begin
         BusA = regs[RA];
      end
      if (RB != XZR) begin
         BusB = regs[RB];
      end
`ifdef REGFILE_BYPASS_EN
      // RW != XZR is implied by wr_ok, so a forwarded read never hits XZR.
      if (wr_ok && !Reset && (RA == RW)) begin
         BusA = BusW;
      end
      if (wr_ok && !Reset && (RB == RW)) begin
         BusB = BusW;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: an architectural model (plain array
// of 32 values) checked against both read ports on every falling edge, plus
// directed vectors with literal expectations.
module tb_register_file;

   logic        Clk;
   logic        Reset;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic [4:0]  RW;
   logic        RegWr;
   logic [63:0] BusW;
   logic [63:0] BusA;
   logic [63:0] BusB;

   int n_total;
   int n_pass;
   bit run_cmp;

   logic [63:0] model_mem [0:31];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   register_file dut (
      .Clk   (Clk),
      .Reset (Reset),
      .RA    (RA),
      .RB    (RB),
      .RW    (RW),
      .RegWr (RegWr),
      .BusW  (BusW),
      .BusA  (BusA),
      .BusB  (BusB)
   );

   // Clock / reset block
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Architectural model: reset clears everything, writes land on the edge.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) model_mem[i] = 64'h0;
      end else if (RegWr && RW != 5'd31) begin
         model_mem[RW] = BusW;
      end
   end

   function automatic logic [63:0] model_read(input logic [4:0] addr);
      if (addr == 5'd31) return 64'h0;
      if (BYP && RegWr && !Reset && RW != 5'd31 && addr == RW) return BusW;
      return model_mem[addr];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: both ports against the model on every falling edge.
   always @(negedge Clk) begin
      if (run_cmp) begin
         check("model_busa", BusA, model_read(RA));
         check("model_busb", BusB, model_read(RB));
      end
   end

   // Driver tasks
   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                        input logic wr, input logic [63:0] w);
      RA = ra;
      RB = rb;
      RW = rw;
      RegWr = wr;
      BusW = w;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      run_cmp = 1'b0;
      Reset = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 64'h0);

      // Reset asserted mid-cycle: every address reads zero at once.
      cyc();
      Reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         RA = 5'(i);
         RB = 5'(31 - i);
         #1;
         check("reset_busa", BusA, 64'h0);
         check("reset_busb", BusB, 64'h0);
      end
      cyc();
      Reset = 1'b0;
      run_cmp = 1'b1;

      // Write / readback of X5.
      drive(5'd5, 5'd4, 5'd5, 1'b1, 64'hDEAD_BEEF_0123_4567);
      #1;
      check("wr_pre_edge", BusA, BYP ? 64'hDEAD_BEEF_0123_4567 : 64'h0);
      cyc();
      RegWr = 1'b0;
      #1;
      check("wr_readback_a", BusA, 64'hDEAD_BEEF_0123_4567);
      check("wr_neighbour_b", BusB, 64'h0);

      // XZR ignores writes and reads zero, even during the write.
      drive(5'd31, 5'd31, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      check("xzr_pre_edge", BusA, 64'h0);
      cyc();
      RegWr = 1'b0;
      #1;
      check("xzr_after_a", BusA, 64'h0);
      check("xzr_after_b", BusB, 64'h0);

      // Write disable keeps X7.
      drive(5'd7, 5'd7, 5'd7, 1'b1, 64'h10);
      cyc();
      drive(5'd7, 5'd7, 5'd7, 1'b0, 64'h99);
      cyc();
      #1;
      check("wr_disable", BusA, 64'h10);

      // Same-cycle read/write hazard on X3.
      drive(5'd0, 5'd0, 5'd3, 1'b1, 64'h1);
      cyc();
      drive(5'd3, 5'd3, 5'd3, 1'b1, 64'h2);
      #1;
      check("hazard_pre_a", BusA, BYP ? 64'h2 : 64'h1);
      check("hazard_pre_b", BusB, BYP ? 64'h2 : 64'h1);
      cyc();
      RegWr = 1'b0;
      #1;
      check("hazard_post_a", BusA, 64'h2);
      check("hazard_post_b", BusB, 64'h2);

      // Reset mid-operation: X9 cleared at once, concurrent write lost.
      drive(5'd9, 5'd3, 5'd9, 1'b1, 64'hAB);
      cyc();
      RegWr = 1'b0;
      #1;
      check("x9_written", BusA, 64'hAB);
      drive(5'd9, 5'd3, 5'd9, 1'b1, 64'h77);
      Reset = 1'b1;
      #1;
      check("mid_reset_a", BusA, 64'h0);
      check("mid_reset_b", BusB, 64'h0);
      cyc();
      #1;
      check("reset_write_lost", BusA, 64'h0);
      Reset = 1'b0;
      BusW = 64'hCD;
      #1;
      check("post_reset_pre", BusA, BYP ? 64'hCD : 64'h0);
      cyc();
      RegWr = 1'b0;
      #1;
      check("post_reset_write", BusA, 64'hCD);

      // Fill entries 0..30 with distinct values, then read all back in pairs.
      for (int i = 0; i < 31; i++) begin
         drive(5'(i), 5'(30 - i), 5'(i), 1'b1, 64'h1000_0000_0000_0000 + 64'(i * 3));
         cyc();
      end
      RegWr = 1'b0;
      for (int i = 0; i < 32; i++) begin
         RA = 5'(i);
         RB = 5'(31 - i);
         #1;
         check("fill_a", BusA, (i == 31) ? 64'h0 : 64'h1000_0000_0000_0000 + 64'(i * 3));
         cyc();
      end

      run_cmp = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
